pred_add_seq: RTL and testbench

//  Sequencer for a parity-predicted ripple-carry adder slice. Splits wide operands into SLICE_W-bit slices.

---
 rtl/pred_add_pkg.sv | 28 ++
 rtl/pred_add_seq_slice.sv | 32 +++
 rtl/pred_add_seq.sv | 196 +++++++++++++++++++
 tb/tb_pred_add_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_add_pkg.sv
// Shared types and helpers for the parity-predicted adder sequencer.
package pred_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned ERR_CNT_W = 8;
  // Widest operand the slice-select helper can address.
  localparam int unsigned SEL_W     = 64;

  // Return the w-bit slice number idx of op, right-aligned and zero-extended.
  function automatic logic [SEL_W-1:0] slice_sel(input logic [SEL_W-1:0] op,
                                                 input int unsigned       idx,
                                                 input int unsigned       w);
    logic [SEL_W-1:0] mask;
    mask = (SEL_W'(1) << w) - SEL_W'(1);
    return (op >> (idx * w)) & mask;
  endfunction

  // Saturating increment for the error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pred_add_seq_slice.sv
// Ripple-carry slice adder with carry-parity prediction check.
module pred_add_slice #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         err_o
);

  logic [W:0]   c;
  logic [W-1:0] s;

  // Bitwise ripple: c[0] is the slice carry-in, c[i+1] the carry out of bit i.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin_i;
    for (int i = 0; i < int'(W); i++) begin
      s[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o    = s;
  assign cout_o = c[W];
  // Sum parity must equal operand parities xor the parity of the carries into each bit.
  assign err_o  = (^s) ^ (^a_i) ^ (^b_i) ^ (^c[W-1:0]);

endmodule

// File: rtl/pred_add_seq.sv
// Slice-serial adder sequencer with per-slice parity check and bounded retry.
// Optional error injection (ports inj_mode/inj_slice) is built when PRED_ADD_ERRINJ_EN is defined.
module pred_add_seq
  import pred_add_pkg::*;
#(
  parameter int unsigned SLICE_W    = 3,
  parameter int unsigned NUM_SLICES = 4,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0]   req_a,
  input  logic [SLICE_W*NUM_SLICES-1:0]   req_b,
  input  logic                            req_cin,
`ifdef PRED_ADD_ERRINJ_EN
  input  logic [1:0]                      inj_mode,
  input  logic [$clog2(NUM_SLICES)-1:0]   inj_slice,
`endif
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [SLICE_W*NUM_SLICES-1:0]   rsp_sum,
  output logic                            rsp_cout,
  output logic                            rsp_fault,
  output logic                            busy,
  output logic [ERR_CNT_W-1:0]            err_cnt
);

  localparam int unsigned OP_W  = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      a_q, a_d;
  logic [OP_W-1:0]      b_q, b_d;
  logic [OP_W-1:0]      sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RTY_W-1:0]     retry_q, retry_d;
  logic                 fault_q, fault_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [SLICE_W-1:0]   a_sl, b_sl, s_raw, s_eff;
  logic                 cout_raw, err_raw, slice_err, retry_left;

  assign a_sl = SLICE_W'(slice_sel(SEL_W'(a_q), 32'(idx_q), SLICE_W));
  assign b_sl = SLICE_W'(slice_sel(SEL_W'(b_q), 32'(idx_q), SLICE_W));

  pred_add_slice #(.W(SLICE_W)) u_slice (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .s_o    (s_raw),
    .cout_o (cout_raw),
    .err_o  (err_raw)
  );

`ifdef PRED_ADD_ERRINJ_EN
  logic [1:0]       inj_mode_q, inj_mode_d;
  logic [IDX_W-1:0] inj_slice_q, inj_slice_d;
  logic             flip;

  // Corrupt bit 0 of the targeted slice: first attempt only (mode 1) or every attempt (mode 2).
  always_comb begin
    flip = 1'b0;
    if (idx_q == inj_slice_q) begin
      flip = (inj_mode_q == 2'd2) || ((inj_mode_q == 2'd1) && (retry_q == '0));
    end
  end

  assign s_eff     = s_raw ^ SLICE_W'(flip);
  assign slice_err = err_raw ^ flip;

  // Injection controls captured with the request.
  always_comb begin
    inj_mode_d  = inj_mode_q;
    inj_slice_d = inj_slice_q;
    if ((state_q == IDLE) && req_valid) begin
      inj_mode_d  = inj_mode;
      inj_slice_d = IDX_W'(inj_slice);
    end
  end

  // Injection control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_mode_q  <= 2'd0;
      inj_slice_q <= '0;
    end else begin
      inj_mode_q  <= inj_mode_d;
      inj_slice_q <= inj_slice_d;
    end
  end
`else
  assign s_eff     = s_raw;
  assign slice_err = err_raw;
`endif

  assign retry_left = (retry_q < RTY_W'(MAX_RETRY));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept, walk slices with retry, hold response until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = ADD;
      ADD: begin
        if (!slice_err && (idx_q == LAST_IDX)) state_d = RESP;
        if (slice_err && !retry_left)          state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state and datapath registers.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    rsp_sum   = rsp_valid ? sum_q : '0;
    rsp_cout  = rsp_valid & carry_q & ~fault_q;
    rsp_fault = rsp_valid & fault_q;
    err_cnt   = err_cnt_q;
  end

  // Datapath next values: operand capture, slice commit, retry and fault bookkeeping.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    fault_d   = fault_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          carry_d = req_cin;
          idx_d   = '0;
          retry_d = '0;
          sum_d   = '0;
          fault_d = 1'b0;
        end
      end
      ADD: begin
        if (!slice_err) begin
          sum_d[32'(idx_q)*SLICE_W +: SLICE_W] = s_eff;
          carry_d = cout_raw;
          retry_d = '0;
          if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
        end else begin
          err_cnt_d = sat_inc(err_cnt_q);
          if (retry_left) retry_d = retry_q + RTY_W'(1);
          else            fault_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      retry_q   <= '0;
      fault_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      fault_q   <= fault_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_pred_add_seq.sv
// Directed bench for pred_add_seq with a transaction-level reference model.
`timescale 1ns/1ps
module tb_pred_add_seq;

  localparam int unsigned SLICE_W    = 3;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned MAX_RETRY  = 2;
  localparam int unsigned OP_W       = SLICE_W * NUM_SLICES;

  typedef struct {
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            fault;
    logic [7:0]      ecnt;
    int              lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [OP_W-1:0] req_a = '0;
  logic [OP_W-1:0] req_b = '0;
  logic            req_cin = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [OP_W-1:0] rsp_sum;
  logic            rsp_cout;
  logic            rsp_fault;
  logic            busy;
  logic [7:0]      err_cnt;
`ifdef PRED_ADD_ERRINJ_EN
  logic [1:0]      inj_mode = 2'd0;
  logic [1:0]      inj_slice = 2'd0;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int          cyc    = 0;
  int unsigned exp_err = 0;
  exp_t        exp_q[$];
  int          acc_q[$];
  exp_t        cur;
  int          acc_c;
  logic        in_rsp = 1'b0;

  pred_add_seq #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef PRED_ADD_ERRINJ_EN
    .inj_mode  (inj_mode),
    .inj_slice (inj_slice),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_fault (rsp_fault),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Whole-operand model: plain integer addition, retries counted per transaction.
  // lat = clock edges from the accept edge (inclusive) to the edge that raises rsp_valid.
  function automatic exp_t model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                 input logic cin, input int mode, input int sl,
                                 input int unsigned err_before);
    exp_t        e;
    logic [OP_W:0] full;
    int unsigned nerr;
    int          adds;
    full    = (OP_W+1)'(a) + (OP_W+1)'(b) + (OP_W+1)'(cin);
    e.sum   = full[OP_W-1:0];
    e.cout  = full[OP_W];
    e.fault = 1'b0;
    nerr    = 0;
    adds    = NUM_SLICES;
    if (mode == 1) begin
      nerr = 1;
      adds = adds + 1;
    end else if (mode == 2) begin
      nerr    = MAX_RETRY + 1;
      adds    = sl + MAX_RETRY + 1;
      e.fault = 1'b1;
      e.cout  = 1'b0;
      e.sum   = full[OP_W-1:0] & OP_W'((1 << (sl * SLICE_W)) - 1);
    end
    e.ecnt = 8'((err_before + nerr > 255) ? 255 : err_before + nerr);
    e.lat  = adds + 1;
    return e;
  endfunction

  // Response checker: every cycle rsp_valid is high, against the head expectation.
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      if (!in_rsp) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got sum 0x%0h with no request outstanding", rsp_sum);
        end else begin
          cur   = exp_q.pop_front();
          acc_c = acc_q.pop_front();
          chk("rsp_sum",   32'(rsp_sum),   32'(cur.sum));
          chk("rsp_cout",  32'(rsp_cout),  32'(cur.cout));
          chk("rsp_fault", 32'(rsp_fault), 32'(cur.fault));
          chk("err_cnt",   32'(err_cnt),   32'(cur.ecnt));
          chk("latency",   32'(cyc - acc_c + 1), 32'(cur.lat));
        end
        in_rsp = 1'b1;
      end else begin
        chk("hold_sum",   32'(rsp_sum),   32'(cur.sum));
        chk("hold_cout",  32'(rsp_cout),  32'(cur.cout));
        chk("hold_fault", 32'(rsp_fault), 32'(cur.fault));
      end
      chk("rsp_req_ready", 32'(req_ready), 32'(0));
      chk("rsp_busy",      32'(busy),      32'(1));
      if (rsp_ready) in_rsp = 1'b0;
    end
  end

  task automatic wait_accept(output int acc);
    bit done;
    done = 0;
    acc  = -1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc  = cyc;
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 for 64 cycles, expected 1");
    end else begin
      acc_q.push_back(acc);
    end
  endtask

  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      input logic cin, input int mode, input int sl);
    exp_t e;
    int   acc;
    e       = model(a, b, cin, mode, sl, exp_err);
    exp_err = e.ecnt;
    exp_q.push_back(e);
    req_a   = a;
    req_b   = b;
    req_cin = cin;
`ifdef PRED_ADD_ERRINJ_EN
    inj_mode  = 2'(mode);
    inj_slice = 2'(sl);
`endif
    req_valid = 1'b1;
    wait_accept(acc);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || rsp_valid) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (i >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [OP_W-1:0] va[4];
    logic [OP_W-1:0] vb[4];
    logic            vc[4];
    int              acc, prev;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'(1));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_rsp_sum",   32'(rsp_sum),   32'(0));
    chk("reset_rsp_cout",  32'(rsp_cout),  32'(0));
    chk("reset_rsp_fault", 32'(rsp_fault), 32'(0));
    chk("reset_busy",      32'(busy),      32'(0));
    chk("reset_err_cnt",   32'(err_cnt),   32'(0));

    // Hand-computed pins on the model.
    e = model(12'hFFF, 12'h001, 1'b0, 0, 0, 0);
    chk("pin1_sum", 32'(e.sum), 32'h000);
    chk("pin1_cout", 32'(e.cout), 32'(1));
    chk("pin1_lat", 32'(e.lat), 32'(5));
    e = model(12'h555, 12'h2AA, 1'b1, 0, 0, 0);
    chk("pin2_sum", 32'(e.sum), 32'h800);
    chk("pin2_cout", 32'(e.cout), 32'(0));
    e = model(12'h123, 12'h456, 1'b0, 1, 2, 0);
    chk("pin3_sum", 32'(e.sum), 32'h579);
    chk("pin3_lat", 32'(e.lat), 32'(6));
    chk("pin3_ecnt", 32'(e.ecnt), 32'(1));
    e = model(12'h123, 12'h456, 1'b0, 2, 1, 1);
    chk("pin4_sum", 32'(e.sum), 32'h001);
    chk("pin4_fault", 32'(e.fault), 32'(1));
    chk("pin4_ecnt", 32'(e.ecnt), 32'(4));
    chk("pin4_lat", 32'(e.lat), 32'(5));

    // Wraparound with carry-out.
    @(posedge clk);
    #1;
    send(12'hFFF, 12'h001, 1'b0, 0, 0);
    drain();

    // Consumer stalls three cycles; response must hold steady.
    rsp_ready = 1'b0;
    send(12'h555, 12'h2AA, 1'b1, 0, 0);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // Assorted directed operands.
    send(12'hABC, 12'h543, 1'b0, 0, 0); drain();
    send(12'h000, 12'h000, 1'b1, 0, 0); drain();
    send(12'h800, 12'h800, 1'b0, 0, 0); drain();
    send(12'h7FF, 12'h000, 1'b1, 0, 0); drain();
    send(12'h123, 12'h456, 1'b0, 0, 0); drain();

`ifdef PRED_ADD_ERRINJ_EN
    // Single transient error on slice 2, then a sticky one on slice 1.
    send(12'h123, 12'h456, 1'b0, 1, 2); drain();
    send(12'h123, 12'h456, 1'b0, 2, 1); drain();
    send(12'hFFF, 12'h001, 1'b1, 1, 3); drain();
    send(12'h0F0, 12'h00F, 1'b0, 2, 0); drain();
    send(12'h321, 12'h111, 1'b0, 0, 0); drain();
`endif

    // Abort mid-operation at slice index 2.
    send(12'h321, 12'h123, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    exp_err = 0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'(1));
    chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("abort_err_cnt",   32'(err_cnt),   32'(0));
    chk("abort_busy",      32'(busy),      32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
    end

    // Back-to-back requests with req_valid held high.
    va[0] = 12'h111; vb[0] = 12'h222; vc[0] = 1'b0;
    va[1] = 12'hFFF; vb[1] = 12'hFFF; vc[1] = 1'b1;
    va[2] = 12'h9A5; vb[2] = 12'h35B; vc[2] = 1'b0;
    va[3] = 12'h001; vb[3] = 12'h7FE; vc[3] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      e       = model(va[k], vb[k], vc[k], 0, 0, exp_err);
      exp_err = e.ecnt;
      exp_q.push_back(e);
    end
    rsp_ready = 1'b1;
`ifdef PRED_ADD_ERRINJ_EN
    inj_mode = 2'd0;
`endif
    req_a = va[0]; req_b = vb[0]; req_cin = vc[0];
    req_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(acc);
      if (k > 0) chk("b2b_period", 32'(acc - prev), 32'(NUM_SLICES + 2));
      prev = acc;
      if (k < 3) begin
        req_a = va[k+1]; req_b = vb[k+1]; req_cin = vc[k+1];
      end else begin
        req_valid = 1'b0;
      end
    end
    drain();
    chk("b2b_all_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
